// File: rtl/burst_mem_responder_if.sv
// Cache-to-memory burst bus: request channel, write-beat channel, read-beat channel
// and write-response channel.
interface burst_mem_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32
);
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_write;
    logic [DATA_ADDR_WIDTH-1:0] req_addr;

    logic                       wdata_valid;
    logic                       wdata_ready;
    logic [DATA_WIDTH-1:0]      wdata;
    logic                       wdata_last;

    logic                       rdata_valid;
    logic                       rdata_ready;
    logic [DATA_WIDTH-1:0]      rdata;
    logic                       rdata_last;

    logic                       wresp_valid;
    logic                       wresp_ready;
    logic                       wresp_err;

    modport master (
        output req_valid, req_write, req_addr,
        output wdata_valid, wdata, wdata_last,
        output rdata_ready, wresp_ready,
        input  req_ready, wdata_ready,
        input  rdata_valid, rdata, rdata_last,
        input  wresp_valid, wresp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr,
        input  wdata_valid, wdata, wdata_last,
        input  rdata_ready, wresp_ready,
        output req_ready, wdata_ready,
        output rdata_valid, rdata, rdata_last,
        output wresp_valid, wresp_err
    );
endinterface

// File: rtl/burst_mem_responder.sv
// Memory-side responder for cache line-fill reads and write-back writes, backed by a
// word-addressed array that reset leaves untouched.
module burst_mem_responder #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int NUM_WORDS       = 128,
    parameter int READ_BURST_LEN  = 8,
    parameter int WRITE_BURST_LEN = 8,
    parameter int READ_LATENCY    = 2
) (
    input logic        sys_clk,
    input logic        sys_rst,
    burst_mem_if.slave bus
);
    localparam int BYTE_OFF = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W    = $clog2(NUM_WORDS);
    localparam int RB_W     = (READ_BURST_LEN > 1) ? $clog2(READ_BURST_LEN) : 1;
    localparam int WB_W     = (WRITE_BURST_LEN > 1) ? $clog2(WRITE_BURST_LEN) : 1;
    localparam int LAT_W    = $clog2(READ_LATENCY + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        WR_RESP
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

    logic [IDX_W-1:0]      base_q;
    logic [RB_W-1:0]       rd_beat;
    logic [WB_W-1:0]       wr_beat;
    logic [LAT_W-1:0]      lat_cnt;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [IDX_W-1:0] req_word;
    logic [IDX_W-1:0] rd_base;
    logic [IDX_W-1:0] wr_base;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             req_xfer;
    logic             rd_xfer;
    logic             wr_xfer;
    logic             resp_xfer;
    logic             rd_last_beat;
    logic             wr_final_beat;
    logic             lat_done;
    logic             unused_addr_bits;

    // Byte offset and bits above the array depth are dropped; the base snaps down to a burst boundary.
    assign req_word         = bus.req_addr[BYTE_OFF +: IDX_W];
    assign rd_base          = req_word & ~IDX_W'(READ_BURST_LEN - 1);
    assign wr_base          = req_word & ~IDX_W'(WRITE_BURST_LEN - 1);
    assign unused_addr_bits = ^bus.req_addr;

    assign rd_idx        = base_q + IDX_W'(rd_beat);
    assign wr_idx        = base_q + IDX_W'(wr_beat);
    assign rd_last_beat  = (rd_beat == RB_W'(READ_BURST_LEN - 1));
    assign wr_final_beat = (wr_beat == WB_W'(WRITE_BURST_LEN - 1));
    assign lat_done      = (lat_cnt == LAT_W'(1));

    assign req_xfer  = (state == IDLE) && bus.req_valid;
    assign rd_xfer   = (state == RD_BURST) && bus.rdata_ready;
    assign wr_xfer   = (state == WR_BURST) && bus.wdata_valid;
    assign resp_xfer = (state == WR_RESP) && bus.wresp_ready;

    assign bus.rdata = rdata_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        bus.req_ready   = 1'b0;
        bus.wdata_ready = 1'b0;
        bus.rdata_valid = 1'b0;
        bus.rdata_last  = 1'b0;
        bus.wresp_valid = 1'b0;
        bus.wresp_err   = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_next = bus.req_write ? WR_BURST : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_done) begin
                    state_next = RD_BURST;
                end
            end
            RD_BURST: begin
                bus.rdata_valid = 1'b1;
                bus.rdata_last  = rd_last_beat;
                if (bus.rdata_ready && rd_last_beat) begin
                    state_next = IDLE;
                end
            end
            WR_BURST: begin
                bus.wdata_ready = 1'b1;
                if (bus.wdata_valid && (bus.wdata_last || wr_final_beat)) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                bus.wresp_valid = 1'b1;
                bus.wresp_err   = err_q;
                if (bus.wresp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // rdata is prefetched one beat ahead so each presented beat comes straight from a register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            base_q  <= '0;
            rd_beat <= '0;
            wr_beat <= '0;
            lat_cnt <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (req_xfer) begin
                base_q  <= bus.req_write ? wr_base : rd_base;
                rd_beat <= '0;
                wr_beat <= '0;
                lat_cnt <= LAT_W'(READ_LATENCY);
                err_q   <= 1'b0;
            end
            if (state == RD_WAIT) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
                if (lat_done) begin
                    rdata_q <= mem[rd_idx];
                end
            end
            if (rd_xfer) begin
                rd_beat <= rd_beat + RB_W'(1);
                if (!rd_last_beat) begin
                    rdata_q <= mem[rd_idx + IDX_W'(1)];
                end
            end
            // A last flag off the final beat, either early or missing, marks the burst as malformed.
            if (wr_xfer) begin
                wr_beat <= wr_beat + WB_W'(1);
                if (bus.wdata_last ^ wr_final_beat) begin
                    err_q <= 1'b1;
                end
            end
            if (resp_xfer) begin
                err_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_xfer) begin
            mem[wr_idx] <= bus.wdata;
        end
    end
endmodule

// File: tb/tb_burst_mem_responder.sv
// Self-checking bench for burst_mem_responder: directed vector table, reset corner
// sequences and randomized traffic against an array model of main memory.
module tb_burst_mem_responder;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int NW  = 128;
    localparam int RBL = 8;
    localparam int WBL = 8;
    localparam int RL  = 2;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;

    always #5 sys_clk = ~sys_clk;

    burst_mem_if #(.DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW)) bus ();

    burst_mem_responder #(
        .DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW), .NUM_WORDS(NW),
        .READ_BURST_LEN(RBL), .WRITE_BURST_LEN(WBL), .READ_LATENCY(RL)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus(bus)
    );

    typedef struct {
        string         name;
        bit            is_write;
        logic [AW-1:0] addr;
        int            base;
        int            mode;
        logic [DW-1:0] d0;
        int            last_pos;
        bit            exp_err;
    } vec_t;

    int            checks;
    int            errors;
    logic [DW-1:0] ref_mem [NW];
    vec_t          vecs [12];

    function automatic vec_t mk(input string name, input bit is_write, input logic [AW-1:0] addr,
                                input int base, input int mode, input logic [DW-1:0] d0,
                                input int last_pos, input bit exp_err);
        vec_t v;
        v.name = name; v.is_write = is_write; v.addr = addr; v.base = base;
        v.mode = mode; v.d0 = d0; v.last_pos = last_pos; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_addr    = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        bus.wdata_last  = 1'b0;
        bus.rdata_ready = 1'b0;
        bus.wresp_ready = 1'b0;
    endtask

    task automatic check_reset_outputs();
        checkOutput("rst_req_ready",   bus.req_ready,   1);
        checkOutput("rst_wdata_ready", bus.wdata_ready, 0);
        checkOutput("rst_rdata_valid", bus.rdata_valid, 0);
        checkOutput("rst_rdata_last",  bus.rdata_last,  0);
        checkOutput("rst_rdata",       bus.rdata,       0);
        checkOutput("rst_wresp_valid", bus.wresp_valid, 0);
        checkOutput("rst_wresp_err",   bus.wresp_err,   0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs are checked before any clock edge.
    task automatic reset_pulse();
        idle_inputs();
        sys_rst = 1'b1;
        #2;
        check_reset_outputs();
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
    endtask

    task automatic issue_request(input bit is_write, input logic [AW-1:0] addr, output bit ok);
        int c;
        c = 0;
        while (!bus.req_ready && c < 50) begin
            tick();
            c++;
        end
        ok = bus.req_ready;
        if (!ok) begin
            checkOutput("req_ready_timeout", bus.req_ready, 1);
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_write = is_write;
        bus.req_addr  = addr;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int base, input int stall_mode, input int abort_at);
        bit            ok;
        bit            rdy;
        bit            prev_stall;
        int            lat;
        int            got;
        int            c;
        logic [DW-1:0] held;
        logic          held_last;
        bit            pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        issue_request(1'b0, addr, ok);
        if (!ok) return;
        lat = 0;
        while (!bus.rdata_valid && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput("rd_latency", lat, RL);
        got = 0;
        c = 0;
        prev_stall = 1'b0;
        held = '0;
        held_last = 1'b0;
        while (got < RBL && c < 200) begin
            if (got == abort_at) begin
                reset_pulse();
                return;
            end
            case (stall_mode)
                0:       rdy = 1'b1;
                1:       rdy = pat[c % 4];
                default: rdy = ($urandom_range(0, 1) == 1);
            endcase
            bus.rdata_ready = rdy;
            checkOutput("rd_valid", bus.rdata_valid, 1);
            if (prev_stall) begin
                checkOutput("rd_stall_data", bus.rdata, held);
                checkOutput("rd_stall_last", bus.rdata_last, held_last);
            end
            if (rdy) begin
                checkOutput("rd_data", bus.rdata, ref_mem[(base + got) % NW]);
                checkOutput("rd_last", bus.rdata_last, (got == RBL - 1));
                got++;
            end
            prev_stall = !rdy;
            held = bus.rdata;
            held_last = bus.rdata_last;
            tick();
            c++;
        end
        bus.rdata_ready = 1'b0;
        checkOutput("rd_beats", got, RBL);
        if (stall_mode == 0) checkOutput("rd_consecutive", c, RBL);
        checkOutput("rd_done_valid", bus.rdata_valid, 0);
        checkOutput("rd_done_ready", bus.req_ready, 1);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input int base, input int mode,
                            input logic [DW-1:0] d0, input int last_pos, input bit exp_err,
                            input int abort_at, input bit abort_in_resp);
        bit            ok;
        bit            gap;
        bit            sent;
        int            nbeats;
        int            k;
        int            c;
        logic [DW-1:0] wd [WBL];
        for (int i = 0; i < WBL; i++) wd[i] = mode[1] ? $urandom : d0 + DW'(i);
        nbeats = (last_pos < WBL) ? last_pos + 1 : WBL;
        issue_request(1'b1, addr, ok);
        if (!ok) return;
        k = 0;
        c = 0;
        while (k < nbeats && c < 100) begin
            if (k == abort_at) begin
                reset_pulse();
                return;
            end
            gap = mode[0] && ($urandom_range(0, 2) == 0);
            bus.wdata_valid = !gap;
            bus.wdata       = wd[k];
            bus.wdata_last  = (k == last_pos);
            sent = !gap && bus.wdata_ready;
            tick();
            c++;
            if (sent) begin
                ref_mem[(base + k) % NW] = wd[k];
                k++;
            end
        end
        bus.wdata_valid = 1'b0;
        bus.wdata_last  = 1'b0;
        checkOutput("wr_beats", k, nbeats);
        c = 0;
        while (!bus.wresp_valid && c < 20) begin
            tick();
            c++;
        end
        checkOutput("wresp_valid", bus.wresp_valid, 1);
        checkOutput("wr_ready_low", bus.wdata_ready, 0);
        checkOutput("wresp_err", bus.wresp_err, exp_err);
        if (abort_in_resp) begin
            reset_pulse();
            return;
        end
        repeat ($urandom_range(0, 2)) tick();
        bus.wresp_ready = 1'b1;
        tick();
        bus.wresp_ready = 1'b0;
        checkOutput("wr_done_valid", bus.wresp_valid, 0);
        checkOutput("wr_done_ready", bus.req_ready, 1);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.is_write) do_write(v.addr, v.base, v.mode, v.d0, v.last_pos, v.exp_err, -1, 1'b0);
        else            do_read(v.addr, v.base, v.mode, -1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [AW-1:0] raddr;
        int            rbase;
        int            rlast;
        checks = 0;
        errors = 0;
        idle_inputs();
        #1 sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        check_reset_outputs();
        sys_rst = 1'b0;
        tick();

        // Preload word i with value i through ordinary write bursts.
        for (int b = 0; b < NW / WBL; b++) begin
            do_write(AW'(b * WBL * 4), b * WBL, 0, DW'(b * WBL), WBL - 1, 1'b0, -1, 1'b0);
        end

        vecs[0]  = mk("rd_0x20",        1'b0, 32'h0000_0020,   8, 0, 32'h0,  0,   1'b0);
        vecs[1]  = mk("wr_0x40",        1'b1, 32'h0000_0040,  16, 0, 32'hA0, 7,   1'b0);
        vecs[2]  = mk("rd_0x40",        1'b0, 32'h0000_0040,  16, 0, 32'h0,  0,   1'b0);
        vecs[3]  = mk("rd_top_word",    1'b0, 32'h0000_01FC, 120, 0, 32'h0,  0,   1'b0);
        vecs[4]  = mk("rd_stall_1001",  1'b0, 32'h0000_0040,  16, 1, 32'h0,  0,   1'b0);
        vecs[5]  = mk("wr_early_last",  1'b1, 32'h0000_0100,  64, 0, 32'hB0, 3,   1'b1);
        vecs[6]  = mk("rd_after_early", 1'b0, 32'h0000_0100,  64, 0, 32'h0,  0,   1'b0);
        vecs[7]  = mk("wr_no_last",     1'b1, 32'h0000_0180,  96, 0, 32'hC0, WBL, 1'b1);
        vecs[8]  = mk("rd_after_nolast",1'b0, 32'h0000_0180,  96, 0, 32'h0,  0,   1'b0);
        vecs[9]  = mk("rd_addr_wrap",   1'b0, 32'h0000_023C,   8, 2, 32'h0,  0,   1'b0);
        vecs[10] = mk("wr_wrap_gaps",   1'b1, 32'h0000_021F,   0, 1, 32'hD0, 7,   1'b0);
        vecs[11] = mk("rd_base0_rand",  1'b0, 32'h0000_0004,   0, 2, 32'h0,  0,   1'b0);

        for (int i = 0; i < 12; i++) begin
            $display("[TB] vector %0d %s", i, vecs[i].name);
            applyStimulus(vecs[i]);
        end

        $display("[TB] reset during read beat 4");
        do_read(32'h0000_0020, 8, 0, 4);
        do_read(32'h0000_0020, 8, 0, -1);

        $display("[TB] reset during write beat 2");
        do_write(32'h0000_0060, 24, 0, 32'hE0, 7, 1'b0, 2, 1'b0);
        do_read(32'h0000_0060, 24, 0, -1);

        $display("[TB] reset while an error response is pending");
        do_write(32'h0000_0140, 80, 0, 32'hF0, 2, 1'b1, -1, 1'b1);
        do_write(32'h0000_0140, 80, 0, 32'h70, 7, 1'b0, -1, 1'b0);
        do_read(32'h0000_0140, 80, 0, -1);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 40; n++) begin
            raddr = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                rbase = int'((raddr >> 2) % NW) & ~(WBL - 1);
                rlast = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WBL)) : WBL - 1;
                do_write(raddr, rbase, 2 | int'($urandom_range(0, 1)), '0, rlast, (rlast != WBL - 1), -1, 1'b0);
            end else begin
                rbase = int'((raddr >> 2) % NW) & ~(RBL - 1);
                do_read(raddr, rbase, 2, -1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
